// File: rtl/pipe_skid_stage.sv
// Two-entry skid register stage with flush and a saturating count of flushed entries.
// Latency: one cycle from in_fire to out_* when the stage is empty; one entry per cycle streaming.
// Backpressure: in_ready is a function of state only (low when both registers are full).
module pipe_skid_stage #(
    parameter int DATA_W             = 32,
    parameter int CTRL_W             = 3,
    parameter bit ZERO_DATA_ON_FLUSH = 1'b1,
    parameter int CNT_W              = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_HOLD = 2'd0,
        M_IN   = 2'd1,
        M_SKID = 2'd2,
        M_CLR  = 2'd3
    } main_sel_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } ent_t;

    state_t     state_q;
    state_t     state_d;
    main_sel_t  main_sel;
    logic       skid_ld;
    ent_t       main_q;
    ent_t       skid_q;
    ent_t       in_ent;
    logic       in_fire;
    logic       out_fire;
    logic [1:0] drop_add;
    logic [CNT_W:0] drop_sum;
    logic [CNT_W-1:0] drop_q;

    assign in_ent   = '{ctrl: in_ctrl, data: in_data};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load selection
    always_comb begin
        state_d  = state_q;
        main_sel = M_HOLD;
        skid_ld  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d  = ONE;
                    main_sel = M_IN;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_sel = M_IN;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    // Clearing ctrl on drain keeps the bubble from writing the register file
                    state_d  = EMPTY;
                    main_sel = M_CLR;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d  = ONE;
                    main_sel = M_SKID;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        occupancy = state_q;
        out_ctrl  = main_q.ctrl;
        out_data  = main_q.data;
        drop_cnt  = drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q.ctrl <= '0;
            skid_q.ctrl <= '0;
            if (ZERO_DATA_ON_FLUSH) begin
                main_q.data <= '0;
                skid_q.data <= '0;
            end
        end else begin
            case (main_sel)
                M_IN:    main_q      <= in_ent;
                M_SKID:  main_q      <= skid_q;
                M_CLR:   main_q.ctrl <= '0;
                default: main_q      <= main_q;
            endcase
            if (skid_ld) begin
                skid_q <= in_ent;
            end
        end
    end

    // Held entries minus the one delivered in the flush cycle; the incoming entry is never counted
    assign drop_add = occupancy - {1'b0, out_fire};
    assign drop_sum = {1'b0, drop_q} + {{(CNT_W - 1){1'b0}}, drop_add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (flush) begin
            drop_q <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, reset/saturation sequences and a random run
// against a two-entry FIFO reference model.
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int CW = 3;
    localparam int NW = 2;
    localparam int DROP_MAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] drop_cnt;

    pipe_skid_stage #(
        .DATA_W(DW), .CTRL_W(CW), .ZERO_DATA_ON_FLUSH(1'b1), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q[$];
    int   m_drop = 0;

    typedef struct {
        bit            iv;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        bit            ordy;
        bit            fl;
        bit            e_vld;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        int            e_occ;
        bit            e_rdy;
        int            e_drop;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("occ", 32'(occupancy), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_ctrl", 32'(out_ctrl), 32'(q[0].c));
        end else begin
            chk("bubble_ctrl", 32'(out_ctrl), 32'd0);
        end
    endtask

    // Drive at negedge, update the model at the posedge, compare 1 time unit later
    task automatic step(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit fl);
        int n;
        bit ifire;
        bit ofire;
        int t;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        n     = q.size();
        ifire = iv && (n < 2);
        ofire = (n > 0) && ordy;
        if (fl) begin
            t = m_drop + n - (ofire ? 1 : 0);
            m_drop = (t > DROP_MAX) ? DROP_MAX : t;
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back('{c, d});
        end
        #1;
        check_model();
    endtask

    initial begin
        int sat_exp[4];
        sat_exp = '{1, 2, 3, 3};

        // Streaming
        vt.push_back('{1, 3'd1, 32'd1, 1, 0, 1, 3'd1, 32'd1, 1, 1, 0});
        vt.push_back('{1, 3'd1, 32'd2, 1, 0, 1, 3'd1, 32'd2, 1, 1, 0});
        vt.push_back('{1, 3'd1, 32'd3, 1, 0, 1, 3'd1, 32'd3, 1, 1, 0});
        vt.push_back('{1, 3'd1, 32'd4, 1, 0, 1, 3'd1, 32'd4, 1, 1, 0});
        vt.push_back('{0, 3'd0, 32'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1, 0});
        // Backpressure: 0xC waits upstream while both registers are full
        vt.push_back('{1, 3'd2, 32'hA, 0, 0, 1, 3'd2, 32'hA, 1, 1, 0});
        vt.push_back('{1, 3'd2, 32'hB, 0, 0, 1, 3'd2, 32'hA, 2, 0, 0});
        vt.push_back('{1, 3'd2, 32'hC, 0, 0, 1, 3'd2, 32'hA, 2, 0, 0});
        vt.push_back('{1, 3'd2, 32'hC, 1, 0, 1, 3'd2, 32'hB, 1, 1, 0});
        vt.push_back('{1, 3'd2, 32'hC, 1, 0, 1, 3'd2, 32'hC, 1, 1, 0});
        vt.push_back('{0, 3'd0, 32'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1, 0});
        // Flush while two entries held and downstream stalled
        vt.push_back('{1, 3'd5, 32'h11, 0, 0, 1, 3'd5, 32'h11, 1, 1, 0});
        vt.push_back('{1, 3'd5, 32'h22, 0, 0, 1, 3'd5, 32'h11, 2, 0, 0});
        vt.push_back('{0, 3'd0, 32'd0, 0, 1, 0, 3'd0, 32'd0, 0, 1, 2});
        // Flush with simultaneous accept and deliver in ONE
        vt.push_back('{1, 3'd5, 32'h33, 0, 0, 1, 3'd5, 32'h33, 1, 1, 2});
        vt.push_back('{1, 3'd5, 32'h55, 1, 1, 0, 3'd0, 32'd0, 0, 1, 2});
        vt.push_back('{0, 3'd0, 32'd0, 1, 0, 0, 3'd0, 32'd0, 0, 1, 2});

        // Reset state, observed while rst_n is still low
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].iv, vt[i].c, vt[i].d, vt[i].ordy, vt[i].fl);
            chk($sformatf("vec%0d_vld", i), 32'(out_valid), 32'(vt[i].e_vld));
            chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl), 32'(vt[i].e_ctrl));
            chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vt[i].e_occ));
            chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vt[i].e_drop));
            if (vt[i].e_vld || vt[i].fl)
                chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
        end

        // Asynchronous reset between edges while two entries are held
        step(1, 3'd3, 32'h77, 0, 0);
        step(1, 3'd3, 32'h88, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_ctrl", 32'(out_ctrl), 32'd0);
        chk("arst_data", out_data, 32'd0);
        q.delete();
        m_drop = 0;
        #1;
        rst_n = 1'b1;
        step(1, 3'd4, 32'h99, 1, 0);
        chk("post_rst_accept_occ", 32'(occupancy), 32'd1);
        chk("post_rst_accept_data", out_data, 32'h99);
        step(0, 3'd0, 32'd0, 1, 0);

        // Saturating drop counter: one entry discarded per flush
        for (int i = 0; i < 4; i++) begin
            step(1, 3'd6, 32'(i + 100), 0, 0);
            step(0, 3'd0, 32'd0, 0, 1);
            chk($sformatf("sat%0d", i), 32'(drop_cnt), 32'(sat_exp[i]));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), CW'($urandom), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter: DATA_W, 32, payload width in bits (ALU result, read data, PC+4, rd packed by instantiator).
REQ-002 Parameter: CTRL_W, 3, control width in bits (RegWrite, ResultSrc packed by instantiator).
REQ-003 Parameter: ZERO_DATA_ON_FLUSH, 1, when 1 flush also clears payload registers; when 0 payload registers hold their value.
REQ-004 Parameter: CNT_W, 16, width of the flush-drop counter.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  synchronous flush; discards all held entries.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage can accept; registered.
REQ-011 in_ctrl  input  CTRL_W  upstream control bits.
REQ-012 in_data  input  DATA_W  upstream payload.
REQ-013 out_valid  output  1  downstream entry present; registered.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_ctrl  output  CTRL_W  control to downstream; registered.
REQ-016 out_data  output  DATA_W  payload to downstream; registered.
REQ-017 occupancy  output  2  held entries, 0..2.
REQ-018 drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both evaluated at the rising edge.
REQ-020 Storage: main register (drives out_*) and skid register; states EMPTY (occ 0), ONE (main full), TWO (main and skid full).
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; it SHALL depend only on state, never combinationally on out_ready.
REQ-022 EMPTY: in_fire -> ONE, main <= in; otherwise stay.
REQ-023 ONE: in_fire & out_fire -> ONE, main <= in; in_fire only -> TWO, skid <= in; out_fire only -> EMPTY; neither -> stay.
REQ-024 TWO: out_fire -> ONE, main <= skid; otherwise stay, both registers hold.
REQ-025 Latency: an entry accepted at edge N SHALL appear on out_* after edge N when ahead of it nothing is held; throughput one entry per cycle while out_ready=1.
REQ-026 Ordering SHALL be strictly FIFO; no entry duplicated or lost except by flush.
REQ-027 out_valid = (state != EMPTY); occupancy SHALL equal state encoding 0/1/2.
REQ-028 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble: no register write).
REQ-029 flush=1 at an edge: state -> EMPTY, main and skid ctrl <= 0, payloads <= 0 iff ZERO_DATA_ON_FLUSH=1; overrides all handshake transitions.
REQ-030 Entry presented with in_fire during a flush cycle SHALL be discarded and not counted in drop_cnt; an out_fire in the flush cycle is a completed transfer, not a drop.
REQ-031 drop_cnt SHALL add the number of held entries not consumed by out_fire in the flush cycle (0, 1 or 2), saturating at 2^CNT_W-1.

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk: state EMPTY, in_ready=1, out_valid=0, occupancy=0, all ctrl and payload registers 0, drop_cnt=0.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; first accept allowed at first rising edge after rst_n deasserts.

Verification
REQ-034 Streaming: in_valid=1 with data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-035 Backpressure: out_ready=0, send 0xA,0xB -> occupancy 2, in_ready=0, 0xC held upstream; out_ready=1 -> outputs 0xA,0xB,0xC in order.
REQ-036 Flush while TWO with out_ready=0, ctrl=3'b101 -> next cycle out_valid=0, out_ctrl=0, out_data=0, drop_cnt +2.
REQ-037 Flush with simultaneous in_fire (data 0x55) and out_fire in ONE -> out entry counted delivered, 0x55 absent, drop_cnt unchanged, occupancy 0.
REQ-038 Async reset pulse between clock edges while TWO -> out_valid, occupancy, drop_cnt go 0 before next edge; in_ready=1.
REQ-039 Saturation with CNT_W=2: four flushes each dropping 1 entry -> drop_cnt 1,2,3,3.
